hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard and stall controller for the five-stage RV32 core; successor to the single-mode stall-only control block. Generates per-pipeline-register advance/flush, fetch redirect and operand-forwarding selects. Adds the following over its predecessor:
- Selectable forwarding mode.
- x0-aware hazard checks.
- Multi-cycle execute-op stalling via a latency counter.
- Data-memory wait stalls.
- One-shot redirect per mispredicted branch.
- Saturating stall/flush performance counters.

## Interface
- `XLEN`, 32: PC width.
- `RW`, 5: register-index width.
- `FWD_ENABLE`, 1:
  - 1 = forward from EX/MEM and MEM/WB; stall only on load-use.
  - 0 = no forwarding; stall on any RAW against E or M.
- `LONG_LAT`, 4: total cycles a long op (mul/div) occupies E. Must be ≥1; 1 disables long-op stalling.
- `CNT_W`, 16: performance-counter width.

Ports:
- `clk` input 1: clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `id_valid`, `id_rs1_used`, `id_rs2_used` input 1 each: D-stage instruction valid / source used.
- `id_rs1`, `id_rs2` input RW: D-stage sources.
- `ex_valid`, `ex_wb_en`, `ex_is_load`, `ex_long_op` input 1 each: E-stage attributes.
- `ex_rd` input RW: E-stage destination.
- `mem_valid`, `mem_wb_en`, `mem_req_pending` input 1 each: M-stage attributes; `mem_req_pending` = M instruction awaits data-memory response.
- `mem_rd` input RW.
- `data_mem_rsp_valid` input 1: data-memory response this cycle.
- `mispredict` input 1: branch in E resolved mispredicted.
- `correct_pc` input XLEN: redirect target.
- `pc_advance`, `if_id_advance`, `id_ex_advance`, `ex_mem_advance`, `mem_wb_advance` output 1 each: register captures its input.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` output 1 each: register loads a bubble; overrides advance.
- `set_pc_valid` output 1, `set_pc` output XLEN: fetch redirect.
- `fwd_rs1_sel`, `fwd_rs2_sel` output 2: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB; 3 never driven.
- `stall_count`, `flush_count` output CNT_W.

## Operation
Conditions:
- **Writer match:** valid & wb_en & rd≠0 & rd equals a *used* D source; x0 never matches.
- **mem_wait** = mem_valid & mem_req_pending & !data_mem_rsp_valid.
  - pc, if_id, id_ex, ex_mem advance=0; mem_wb_flush=1.
- **Long-op FSM**, states IDLE/BUSY with down-counter `cnt`:
  - IDLE & ex_valid & ex_long_op & LONG_LAT>1 → BUSY, cnt=LONG_LAT-2; stall this cycle.
  - BUSY & cnt≠0 → cnt-1; stall.
  - BUSY & cnt==0 → no long stall; → IDLE when ex_mem_advance.
  - Counter keeps running during mem_wait.
  - Long stall: pc, if_id, id_ex hold; ex_mem_flush=1.
- **Load-use** (FWD_ENABLE=1): E writer match with ex_is_load & id_valid.
- **RAW** (FWD_ENABLE=0): E or M writer match & id_valid.
- **Load-use/RAW stall:** pc, if_id hold; id_ex_flush=1.
- **Redirect**, one-shot bit `redirect_done`:
  - mispredict & !redirect_done: set_pc_valid=1, set_pc=correct_pc, pc_advance=1, if_id_flush=1, id_ex_flush=1.
  - mispredict & redirect_done: same flushes, no set_pc.
  - redirect_done sets when mispredict & !ex_mem_advance; clears when ex_mem_advance.
- **Priority:** reset > mem_wait (E..pc hold) > mispredict flushes (override long/load-use/RAW stalls on if_id/id_ex/pc) > long op > load-use/RAW. mem_wait and mispredict combine; set_pc still fires.
- **Forwarding** (FWD_ENABLE=1), per source:
  - E writer match & !ex_is_load → 1.
  - Else M writer match → 2.
  - Else 0.
  - Selects are 0 when FWD_ENABLE=0.
- **Counters:** stall_count +1 per cycle with pc_advance=0 & no set_pc; flush_count +1 per set_pc_valid. Both saturate at all-ones.

## Timing
- All outputs are combinational from inputs and state; state updates on the next edge.
- While reset low:
  - All advance=0, all flush=1, set_pc_valid=0, set_pc=0, selects=0.
  - State IDLE, cnt=0, redirect_done=0, counters=0.
- Idle (no hazards): all advance=1, flush=0.
- Load-use costs exactly 1 bubble.
- A long op holds E for exactly LONG_LAT cycles plus any mem_wait cycles.
- Redirect fires on the same cycle as the first mispredict assertion.
- Reset asserted mid-BUSY or mid-redirect aborts immediately.

## Test plan
- **Load-use:** FWD_ENABLE=1, E=load x5, D uses rs1=x5 → one cycle with pc/if_id hold and id_ex_flush; next cycle fwd_rs1_sel=2; stall_count=1.
- **x0 and forwarding:** E writes x0, D uses x0 → no stall, sel=0. E writes x7 (non-load) while M writes x7 → sel=1.
- **Long op:** LONG_LAT=4, ex_long_op → 3 stall cycles with ex_mem_flush, advance on the 4th. LONG_LAT=1 → no stall.
- **Redirect under mem_wait:** mispredict held 3 cycles during mem_wait, correct_pc=0x100 → set_pc_valid exactly once, flushes on all 3 cycles, flush_count=1.
- **FWD_ENABLE=0 RAW:** M writes x3, D uses rs2=x3 → stall, selects 0.
- **Async reset mid-BUSY:** reset in cnt=1 → outputs at reset values immediately; after release, FSM IDLE and counters 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard and stall controller for the five-stage RV32 pipeline.
// Produces stage advance/flush, fetch redirect and forwarding selects.
module hazard_ctrl_unit #(
   parameter int XLEN       = 32,
   parameter int RW         = 5,
   parameter int FWD_ENABLE = 1,
   parameter int LONG_LAT   = 4,
   parameter int CNT_W      = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [RW-1:0]   id_rs1,
   input  logic [RW-1:0]   id_rs2,
   input  logic            ex_valid,
   input  logic            ex_wb_en,
   input  logic            ex_is_load,
   input  logic            ex_long_op,
   input  logic [RW-1:0]   ex_rd,
   input  logic            mem_valid,
   input  logic            mem_wb_en,
   input  logic            mem_req_pending,
   input  logic [RW-1:0]   mem_rd,
   input  logic            data_mem_rsp_valid,
   input  logic            mispredict,
   input  logic [XLEN-1:0] correct_pc,
   output logic            pc_advance,
   output logic            if_id_advance,
   output logic            id_ex_advance,
   output logic            ex_mem_advance,
   output logic            mem_wb_advance,
   output logic            if_id_flush,
   output logic            id_ex_flush,
   output logic            ex_mem_flush,
   output logic            mem_wb_flush,
   output logic            set_pc_valid,
   output logic [XLEN-1:0] set_pc,
   output logic [1:0]      fwd_rs1_sel,
   output logic [1:0]      fwd_rs2_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int CW = (LONG_LAT > 2) ? $clog2(LONG_LAT - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      (LONG_LAT > 2) ? CW'(LONG_LAT - 2) : '0;
   localparam bit LONG_EN = (LONG_LAT > 1);
   localparam bit FWD     = (FWD_ENABLE != 0);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             redirect_done_q, redirect_done_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic e1, e2, m1, m2;
   logic mem_wait, long_start, long_stall, data_stall;

   function automatic logic [1:0] fsel(logic e, logic m, logic ld);
      if (!FWD)         return 2'd0;
      else if (e && !ld) return 2'd1;
      else if (m)       return 2'd2;
      else              return 2'd0;
   endfunction

   always_comb begin
      e1 = ex_valid & ex_wb_en & (ex_rd != '0) & id_rs1_used & (ex_rd == id_rs1);
      e2 = ex_valid & ex_wb_en & (ex_rd != '0) & id_rs2_used & (ex_rd == id_rs2);
      m1 = mem_valid & mem_wb_en & (mem_rd != '0) & id_rs1_used & (mem_rd == id_rs1);
      m2 = mem_valid & mem_wb_en & (mem_rd != '0) & id_rs2_used & (mem_rd == id_rs2);
      mem_wait   = mem_valid & mem_req_pending & ~data_mem_rsp_valid;
      long_start = LONG_EN & (state_q == IDLE) & ex_valid & ex_long_op;
      long_stall = long_start | ((state_q == BUSY) & (cnt_q != '0));
      if (FWD) data_stall = id_valid & ex_is_load & (e1 | e2);
      else     data_stall = id_valid & (e1 | e2 | m1 | m2);
   end

   always_comb begin
      pc_advance     = 1'b1;
      if_id_advance  = 1'b1;
      id_ex_advance  = 1'b1;
      ex_mem_advance = 1'b1;
      mem_wb_advance = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      mem_wb_flush   = 1'b0;
      set_pc_valid   = 1'b0;
      set_pc         = '0;
      fwd_rs1_sel    = fsel(e1, m1, ex_is_load);
      fwd_rs2_sel    = fsel(e2, m2, ex_is_load);
      if (long_stall) begin
         pc_advance    = 1'b0;
         if_id_advance = 1'b0;
         id_ex_advance = 1'b0;
         ex_mem_flush  = 1'b1;
      end else if (data_stall) begin
         pc_advance    = 1'b0;
         if_id_advance = 1'b0;
         id_ex_flush   = 1'b1;
      end
      if (mispredict) begin
         pc_advance    = 1'b1;
         if_id_advance = 1'b1;
         id_ex_advance = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         if (!redirect_done_q) begin
            set_pc_valid = 1'b1;
            set_pc       = correct_pc;
         end
      end
      // Memory wait freezes E..pc; a pending mispredict still squashes D/F
      if (mem_wait) begin
         pc_advance     = 1'b0;
         if_id_advance  = 1'b0;
         id_ex_advance  = 1'b0;
         ex_mem_advance = 1'b0;
         ex_mem_flush   = 1'b0;
         if_id_flush    = mispredict;
         id_ex_flush    = mispredict;
         mem_wb_flush   = 1'b1;
      end
      if (!reset) begin
         pc_advance     = 1'b0;
         if_id_advance  = 1'b0;
         id_ex_advance  = 1'b0;
         ex_mem_advance = 1'b0;
         mem_wb_advance = 1'b0;
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         ex_mem_flush   = 1'b1;
         mem_wb_flush   = 1'b1;
         set_pc_valid   = 1'b0;
         set_pc         = '0;
         fwd_rs1_sel    = 2'd0;
         fwd_rs2_sel    = 2'd0;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      redirect_done_d = redirect_done_q;
      stall_count_d   = stall_count_q;
      flush_count_d   = flush_count_q;
      if (state_q == IDLE) begin
         if (long_start) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else if (ex_mem_advance) begin
         state_d = IDLE;
      end
      if (ex_mem_advance)  redirect_done_d = 1'b0;
      else if (mispredict) redirect_done_d = 1'b1;
      if (!pc_advance && !set_pc_valid && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
      if (set_pc_valid && (flush_count_q != '1))
         flush_count_d = flush_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         redirect_done_q <= 1'b0;
         stall_count_q   <= '0;
         flush_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         redirect_done_q <= redirect_done_d;
         stall_count_q   <= stall_count_d;
         flush_count_q   <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three configurations share stimulus,
// expectations are queued at drive time and drained after settling.
module tb_hazard_ctrl_unit;

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, id_rs1_used, id_rs2_used;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
   logic ex_valid, ex_wb_en, ex_is_load, ex_long_op;
   logic mem_valid, mem_wb_en, mem_req_pending, data_mem_rsp_valid;
   logic mispredict;
   logic [31:0] correct_pc;

   logic pc_adv [3], ifid_adv [3], idex_adv [3], exmem_adv [3], memwb_adv [3];
   logic ifid_fl [3], idex_fl [3], exmem_fl [3], memwb_fl [3], spv [3];
   logic [31:0] spc [3];
   logic [1:0]  s1 [3], s2 [3];
   logic [15:0] sc [3], fc [3];

   always #5 clk = ~clk;

   // inst0: FWD=1 LAT=4, inst1: FWD=0 LAT=4, inst2: FWD=1 LAT=1
   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_ctrl_unit #(
         .XLEN(32), .RW(5),
         .FWD_ENABLE((g == 1) ? 0 : 1),
         .LONG_LAT((g == 2) ? 1 : 4),
         .CNT_W(16)
      ) u_dut (
         .clk(clk), .reset(rst_n),
         .id_valid(id_valid), .id_rs1_used(id_rs1_used),
         .id_rs2_used(id_rs2_used), .id_rs1(id_rs1), .id_rs2(id_rs2),
         .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
         .ex_long_op(ex_long_op), .ex_rd(ex_rd),
         .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
         .mem_req_pending(mem_req_pending), .mem_rd(mem_rd),
         .data_mem_rsp_valid(data_mem_rsp_valid),
         .mispredict(mispredict), .correct_pc(correct_pc),
         .pc_advance(pc_adv[g]), .if_id_advance(ifid_adv[g]),
         .id_ex_advance(idex_adv[g]), .ex_mem_advance(exmem_adv[g]),
         .mem_wb_advance(memwb_adv[g]),
         .if_id_flush(ifid_fl[g]), .id_ex_flush(idex_fl[g]),
         .ex_mem_flush(exmem_fl[g]), .mem_wb_flush(memwb_fl[g]),
         .set_pc_valid(spv[g]), .set_pc(spc[g]),
         .fwd_rs1_sel(s1[g]), .fwd_rs2_sel(s2[g]),
         .stall_count(sc[g]), .flush_count(fc[g])
      );
   end

   // {pc,ifid,idex,exmem,memwb adv | ifid,idex,exmem,memwb flush | spv | s1 | s2}
   localparam logic [13:0] V_RST  = 14'b00000_1111_0_00_00;
   localparam logic [13:0] V_IDLE = 14'b11111_0000_0_00_00;
   localparam logic [13:0] V_LU   = 14'b00111_0100_0_00_00;
   localparam logic [13:0] V_LONG = 14'b00011_0010_0_00_00;
   localparam logic [13:0] V_MW1  = 14'b00001_1101_1_00_00;
   localparam logic [13:0] V_MW   = 14'b00001_1101_0_00_00;
   localparam logic [13:0] V_MP   = 14'b11111_1100_1_00_00;

   typedef struct {
      string       tag;
      int          inst;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] obs(int i, int k);
      case (k)
         0: return 32'({pc_adv[i], ifid_adv[i], idex_adv[i], exmem_adv[i],
                        memwb_adv[i], ifid_fl[i], idex_fl[i], exmem_fl[i],
                        memwb_fl[i], spv[i], s1[i], s2[i]});
         1: return spc[i];
         2: return 32'(sc[i]);
         default: return 32'(fc[i]);
      endcase
   endfunction

   task automatic push(string tag, int inst, int kind, logic [31:0] v);
      exp_t e;
      e.tag = tag; e.inst = inst; e.kind = kind; e.val = v;
      q.push_back(e);
   endtask

   task automatic push3(string tag, logic [13:0] v0, logic [13:0] v1,
                        logic [13:0] v2);
      push(tag, 0, 0, 32'(v0));
      push(tag, 1, 0, 32'(v1));
      push(tag, 2, 0, 32'(v2));
   endtask

   task automatic chk();
      exp_t e;
      logic [31:0] got;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         got = obs(e.inst, e.kind);
         checks++;
         assert (got === e.val) else begin
            errors++;
            $error("FAIL %s inst%0d kind%0d: got %0h expected %0h",
                   e.tag, e.inst, e.kind, got, e.val);
         end
      end
   endtask

   task automatic clr();
      id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
      ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_long_op = 0;
      mem_valid = 0; mem_wb_en = 0; mem_req_pending = 0;
      data_mem_rsp_valid = 0; mispredict = 0; correct_pc = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      @(negedge clk);
      correct_pc = 32'h55;
      push3("reset", V_RST, V_RST, V_RST);
      push("reset_setpc", 0, 1, 32'h0);
      push("reset_stall", 0, 2, 0);
      push("reset_flush", 0, 3, 0);
      chk();
      rst_n = 1'b1;
      correct_pc = '0;
      push3("idle", V_IDLE, V_IDLE, V_IDLE);
      chk();

      // load-use: E=load x5, D reads x5
      @(negedge clk);
      ex_valid = 1; ex_wb_en = 1; ex_is_load = 1; ex_rd = 5'd5;
      id_valid = 1; id_rs1_used = 1; id_rs1 = 5'd5;
      push3("lu_stall", V_LU, V_LU, V_LU);
      chk();
      @(negedge clk);
      ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd = '0;
      mem_valid = 1; mem_wb_en = 1; mem_rd = 5'd5;
      push3("lu_fwd", 14'b11111_0000_0_10_00, V_LU, 14'b11111_0000_0_10_00);
      push("lu_stallcnt", 0, 2, 1);
      chk();

      // x0 never matches
      @(negedge clk);
      clr();
      ex_valid = 1; ex_wb_en = 1; mem_valid = 1; mem_wb_en = 1;
      id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
      push3("x0", V_IDLE, V_IDLE, V_IDLE);
      chk();

      // E and M both write x7: E wins
      @(negedge clk);
      ex_rd = 5'd7; mem_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7;
      push3("fwd_e", 14'b11111_0000_0_01_01, V_LU, 14'b11111_0000_0_01_01);
      chk();
      @(negedge clk);
      mem_rd = 5'd9; id_rs2 = 5'd9;
      push3("fwd_em", 14'b11111_0000_0_01_10, V_LU, 14'b11111_0000_0_01_10);
      chk();

      // M writes x3, D reads rs2=x3
      @(negedge clk);
      clr();
      mem_valid = 1; mem_wb_en = 1; mem_rd = 5'd3;
      id_valid = 1; id_rs2_used = 1; id_rs2 = 5'd3;
      push3("raw_m", 14'b11111_0000_0_00_10, V_LU, 14'b11111_0000_0_00_10);
      chk();
      @(negedge clk);
      id_rs2_used = 0;
      push3("raw_unused", V_IDLE, V_IDLE, V_IDLE);
      chk();

      // long op: 3 stall cycles then advance
      @(negedge clk);
      clr();
      ex_valid = 1; ex_long_op = 1;
      for (int c = 0; c < 3; c++) begin
         push3("long_stall", V_LONG, V_LONG, V_IDLE);
         chk();
         @(negedge clk);
      end
      push3("long_done", V_IDLE, V_IDLE, V_IDLE);
      push("long_stallcnt", 0, 2, 4);
      push("lat1_stallcnt", 2, 2, 1);
      chk();

      // mispredict held 3 cycles under mem_wait
      @(negedge clk);
      clr();
      mem_valid = 1; mem_req_pending = 1;
      mispredict = 1; correct_pc = 32'h100;
      push3("mw_mp1", V_MW1, V_MW1, V_MW1);
      push("mw_setpc", 0, 1, 32'h100);
      chk();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         push3("mw_mp", V_MW, V_MW, V_MW);
         chk();
      end
      @(negedge clk);
      clr();
      push3("mw_after", V_IDLE, V_IDLE, V_IDLE);
      push("mw_flushcnt", 0, 3, 1);
      push("mw_stallcnt", 0, 2, 6);
      chk();

      // plain mispredict redirects again
      @(negedge clk);
      mispredict = 1; correct_pc = 32'h200;
      push3("mp", V_MP, V_MP, V_MP);
      push("mp_setpc", 1, 1, 32'h200);
      chk();
      @(negedge clk);
      clr();
      push("mp_flushcnt", 0, 3, 2);
      chk();

      // async reset with the long-op counter at 1
      @(negedge clk);
      ex_valid = 1; ex_long_op = 1;
      push("rb_stall1", 0, 0, 32'(V_LONG));
      chk();
      @(negedge clk);
      push("rb_stall2", 0, 0, 32'(V_LONG));
      chk();
      @(negedge clk);
      push("rb_precnt", 0, 2, 8);
      chk();
      #2 rst_n = 1'b0;
      push3("rb_reset", V_RST, V_RST, V_RST);
      push("rb_stallcnt", 0, 2, 0);
      push("rb_flushcnt", 0, 3, 0);
      chk();
      clr();
      @(negedge clk);
      rst_n = 1'b1;
      push3("rb_idle", V_IDLE, V_IDLE, V_IDLE);
      chk();
      @(negedge clk);
      ex_valid = 1; ex_long_op = 1;
      push("rb_restart", 0, 0, 32'(V_LONG));
      push("rb_cnt0", 0, 2, 0);
      chk();
      @(negedge clk);
      clr();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
